mem_lsu: RTL
============

// Module: mem_lsu
// PURPOSE
//  Memory stage, directly downstream of exe. Consumes exe's per-instruction bundle:
//   valid, ALU result/address, rs2 data and control.
//  Executes loads/stores over a req/gnt/rvalid data-memory port; registers results toward writeback.
//  Non-memory instructions pass through with 1-cycle latency.
//  Stalls exe via ready_o while a memory transaction is outstanding.
// PARAMETERS
//  MEM_TIMEOUT  255  cycles in REQ+WAIT before abort with bus_err_o (>=2, counter width $clog2(MEM_TIMEOUT+1))
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_i          in   1   synchronous reset, active-high
//  valid_i        in   1   exe bundle valid
//  ready_o        out  1   stage can accept; transfer when valid_i & ready_o
//  is_load_i      in   1   instruction is a load
//  is_store_i     in   1   instruction is a store (never both with is_load_i)
//  size_i         in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  unsigned_i     in   1   load zero-extends (LBU/LHU)
//  addr_i         in   32  ALU result: memory address, or writeback value for non-mem ops
//  store_data_i   in   32  rs2 data for stores
//  rd_i           in   5   destination register
//  dmem_req_o     out  1   memory request
//  dmem_we_o      out  1   1 = write
//  dmem_addr_o    out  32  word-aligned address {addr[31:2],2'b00}
//  dmem_be_o      out  4   byte enables
//  dmem_wdata_o   out  32  lane-replicated store data
//  dmem_gnt_i     in   1   request accepted this cycle
//  dmem_rvalid_i  in   1   read data valid
//  dmem_rdata_i   in   32  read data
//  valid_o        out  1   one-cycle pulse: result to writeback
//  rd_o           out  5   destination register (0 for stores)
//  data_o         out  32  writeback data
//  bus_err_o      out  1   qualified by valid_o; timeout
//  misaligned_o   out  1   qualified by valid_o; misaligned access (MISALIGN_TRAP_EN only, else 0)
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0; all outputs 0 except ready_o=1.
//  FSM IDLE: ready_o=1. Accept on valid_i:
//   - non-mem: valid_o=1, data_o=addr_i, rd_o=rd_i next cycle; stay IDLE.
//   - load/store: latch fields; go REQ.
//  FSM REQ: dmem_req_o=1, addr/we/be/wdata stable until gnt.
//   - gnt & store -> IDLE, valid_o next cycle, rd_o=0.
//   - gnt & load & rvalid same cycle -> complete as from WAIT.
//   - gnt & load -> WAIT.
//  FSM WAIT: req=0. rvalid -> extract, register data_o, valid_o next cycle -> IDLE.
//  ready_o=0 in REQ/WAIT; back-to-back only through IDLE.
//   - Min latency from accept edge N: ALU N+1; store N+2; load N+3 with gnt at N+1, rvalid at N+2.
//  Byte enables: B 4'b0001<<a[1:0]; H 4'b0011<<{a[1],1'b0}; W 4'b1111.
//   - wdata: B {4{d[7:0]}}, H {2{d[15:0]}}, W d.
//  Load extract: byte lane a[1:0], half lane a[1]; sign/zero extend per unsigned_i to 32b.
//  Timeout: counter clears on entry to REQ and counts every REQ/WAIT cycle.
//   - At MEM_TIMEOUT: valid_o=1, bus_err_o=1, data_o=0, state IDLE, dmem_req_o drops.
//   - Late rvalid in IDLE is ignored.
//  Reset mid-transaction: next cycle IDLE, req=0, no valid_o; in-flight access dropped.
//  valid_i while ready_o=0: ignored; exe must hold its bundle.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - Half with a[0]=1, or word with a[1:0]!=0: no memory request, state stays IDLE.
//   - Next cycle valid_o=1, misaligned_o=1, data_o=addr_i.
//  Not defined: misaligned_o tied 0.
//   - Low address bits beyond the access size are ignored: half uses a[1]; word is fully aligned.
// TESTING
//  ALU op addr_i=0x1234, rd=5, accept at N -> N+1 valid_o=1, data_o=0x1234, rd_o=5, req never high.
//  SB addr 0x103, data 0xAB, gnt 2 cycles late -> be=4'b1000, wdata=0xABABABAB held until gnt, valid_o rd_o=0.
//  LB addr 0x102, rdata 0x00800000 -> data_o=0xFFFFFF80; LBU -> 0x00000080; LH addr 0x2, rdata 0x80000000 -> 0xFFFF8000.
//  Load with gnt&rvalid same cycle, then gnt withheld MEM_TIMEOUT cycles on next -> first completes normally; second gives bus_err_o=1, ready_o=1.
//  rst_i pulsed in WAIT, then rvalid arrives -> no valid_o, ready_o=1, req=0.
//  MISALIGN_TRAP_EN: LW addr 0x101 -> no req, valid_o next cycle misaligned_o=1; undefined: req addr 0x100, be=4'b1111.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory stage: runs loads/stores over a req/gnt/rvalid port and registers results toward writeback.
// Optional build macro MISALIGN_TRAP_EN reports misaligned half/word accesses instead of issuing them.
module mem_lsu #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        valid_o,
    output logic [4:0]  rd_o,
    output logic [31:0] data_o,
    output logic        bus_err_o,
    output logic        misaligned_o
);
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              dmem_we_q;
    logic [31:0]       dmem_addr_q;
    logic [3:0]        dmem_be_q;
    logic [31:0]       dmem_wdata_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [4:0]        ld_rd_q;
    logic              valid_q;
    logic [4:0]        rd_q;
    logic [31:0]       data_q;
    logic              bus_err_q;

    logic              is_mem_d;
    logic              timeout_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [7:0]        byte_d;
    logic [15:0]       half_d;
    logic [31:0]       load_data_d;

`ifdef MISALIGN_TRAP_EN
    logic              misaligned_q;
    logic              misaligned_d;

    assign misaligned_d = ((size_i == 2'b01) && addr_i[0]) ||
                          (size_i[1] && (addr_i[1:0] != 2'b00));
    assign misaligned_o = misaligned_q;
`else
    assign misaligned_o = 1'b0;
`endif

    assign is_mem_d  = is_load_i | is_store_i;
    assign timeout_d = (cnt_q >= CNT_W'(MEM_TIMEOUT - 1));

    // Lane placement of the outgoing store; reserved size 11 behaves as a word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data_i;
        case (size_i)
            2'b00: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_d = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_d = dmem_rdata_i[7:0];
        case (lane_q)
            2'b01:   byte_d = dmem_rdata_i[15:8];
            2'b10:   byte_d = dmem_rdata_i[23:16];
            2'b11:   byte_d = dmem_rdata_i[31:24];
            default: ;
        endcase
        half_d      = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_data_d = dmem_rdata_i;
        case (size_q)
            2'b00:   load_data_d = unsigned_q ? {24'd0, byte_d} : {{24{byte_d[7]}}, byte_d};
            2'b01:   load_data_d = unsigned_q ? {16'd0, half_d} : {{16{half_d[15]}}, half_d};
            default: ;
        endcase
    end

    // A completion that lands on the timeout cycle wins over the abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            lane_q       <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            ld_rd_q      <= '0;
            valid_q      <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
            bus_err_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            valid_q   <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        if (!is_mem_d) begin
                            valid_q <= 1'b1;
                            data_q  <= addr_i;
                            rd_q    <= rd_i;
                        end
`ifdef MISALIGN_TRAP_EN
                        else if (misaligned_d) begin
                            valid_q      <= 1'b1;
                            misaligned_q <= 1'b1;
                            data_q       <= addr_i;
                            rd_q         <= is_store_i ? 5'd0 : rd_i;
                        end
`endif
                        else begin
                            state_q      <= REQ;
                            cnt_q        <= '0;
                            dmem_we_q    <= is_store_i;
                            dmem_addr_q  <= {addr_i[31:2], 2'b00};
                            dmem_be_q    <= be_d;
                            dmem_wdata_q <= wdata_d;
                            lane_q       <= addr_i[1:0];
                            size_q       <= size_i;
                            unsigned_q   <= unsigned_i;
                            ld_rd_q      <= rd_i;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i && dmem_we_q) begin
                        state_q <= IDLE;
                        valid_q <= 1'b1;
                        rd_q    <= 5'd0;
                        data_q  <= '0;
                    end else if (dmem_gnt_i && dmem_rvalid_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b1;
                        rd_q    <= ld_rd_q;
                        data_q  <= load_data_d;
                    end else if (timeout_d) begin
                        state_q   <= IDLE;
                        valid_q   <= 1'b1;
                        bus_err_q <= 1'b1;
                        rd_q      <= 5'd0;
                        data_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (dmem_gnt_i) begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b1;
                        rd_q    <= ld_rd_q;
                        data_q  <= load_data_d;
                    end else if (timeout_d) begin
                        state_q   <= IDLE;
                        valid_q   <= 1'b1;
                        bus_err_q <= 1'b1;
                        rd_q      <= 5'd0;
                        data_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_be_o    = dmem_be_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign valid_o      = valid_q;
    assign rd_o         = rd_q;
    assign data_o       = data_q;
    assign bus_err_o    = bus_err_q;

endmodule
